// File: rtl/jk_switch_conditioner_if.sv
// jk_switch_conditioner_if: raw switch levels in, conditioned flip-flop control levels out.
interface jk_switch_conditioner_if;
    logic input_input_switch2__preset_3;
    logic input_input_switch3__clear_4;
    logic input_input_switch4_j_5;
    logic input_input_switch5_k_6;
    logic input_push_button6_step_7;
    logic output_preset_n_db_8;
    logic output_clear_n_db_9;
    logic output_j_db_10;
    logic output_k_db_11;
    logic output_step_tick_12;
    logic output_conflict_13;

    modport master (
        output input_input_switch2__preset_3,
        output input_input_switch3__clear_4,
        output input_input_switch4_j_5,
        output input_input_switch5_k_6,
        output input_push_button6_step_7,
        input  output_preset_n_db_8,
        input  output_clear_n_db_9,
        input  output_j_db_10,
        input  output_k_db_11,
        input  output_step_tick_12,
        input  output_conflict_13
    );

    modport slave (
        input  input_input_switch2__preset_3,
        input  input_input_switch3__clear_4,
        input  input_input_switch4_j_5,
        input  input_input_switch5_k_6,
        input  input_push_button6_step_7,
        output output_preset_n_db_8,
        output output_clear_n_db_9,
        output output_j_db_10,
        output output_k_db_11,
        output output_step_tick_12,
        output output_conflict_13
    );
endinterface

// File: rtl/jk_switch_conditioner.sv
// jk_switch_conditioner: synchronizes and debounces five raw switches, emits a step tick and a preset/clear conflict flag.
module jk_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic input_clock1_c_1,
    input logic input_input_switch1_reset_2,
    jk_switch_conditioner_if.slave io
);
    localparam int NCH = 5;
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    // channel order: step, k, j, clear, preset (bit 0)
    localparam logic [NCH-1:0] RST_VAL = 5'b00011;

    logic clk;
    logic rst;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync;
    logic [NCH-1:0] db;

    assign clk = input_clock1_c_1;
    assign rst = input_input_switch1_reset_2;
    assign raw = {io.input_push_button6_step_7, io.input_input_switch5_k_6, io.input_input_switch4_j_5,
                  io.input_input_switch3__clear_4, io.input_input_switch2__preset_3};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic db_q;
        logic db_d;
        logic s;
        assign s = sync_q[SYNC_STAGES-1];
        always_comb begin
            cnt_d = (s == db_q || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            db_d = (s != db_q && cnt_q == LAST) ? s : db_q;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= {SYNC_STAGES{RST_VAL[c]}};
                cnt_q <= '0;
                db_q <= RST_VAL[c];
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[c]};
                cnt_q <= cnt_d;
                db_q <= db_d;
            end
        end
        assign sync[c] = s;
        assign db[c] = db_q;
    end

    // A step held through reset must be seen released before it may tick;
    // fill_q marks when the synchronizer holds genuine post-reset samples.
    logic [SYNC_STAGES-1:0] fill_q;
    logic armed_q;
    logic armed_d;
    logic step_prev_q;
    logic tick_q;
    logic tick_d;
    logic conflict_q;
    logic conflict_d;

    always_comb begin
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~sync[4]);
        tick_d = db[4] & ~step_prev_q & armed_q;
        conflict_d = ~(db[0] | db[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
            armed_q <= 1'b0;
            step_prev_q <= 1'b0;
            tick_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            armed_q <= armed_d;
            step_prev_q <= db[4];
            tick_q <= tick_d;
            conflict_q <= conflict_d;
        end
    end

    assign io.output_preset_n_db_8 = db[0];
    assign io.output_clear_n_db_9 = db[1];
    assign io.output_j_db_10 = db[2];
    assign io.output_k_db_11 = db[3];
    assign io.output_step_tick_12 = tick_q;
    assign io.output_conflict_13 = conflict_q;
endmodule

// File: tb/tb_jk_switch_conditioner.sv
// tb_jk_switch_conditioner: directed and random stimulus checked each cycle against a history-based model.
module tb_jk_switch_conditioner;
    localparam int D = 16;
    localparam int S = 2;
    localparam int MAXN = 8192;
    localparam bit [4:0] RV = 5'b00011;
    localparam bit [4:0] IDLE = 5'b00011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    jk_switch_conditioner_if bus ();

    jk_switch_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .input_clock1_c_1(clk),
        .input_input_switch1_reset_2(rst),
        .io(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n = 0;
    int last_rst = 0;
    bit rawh[5][MAXN];
    bit dh[5][MAXN];
    bit exp_tick = 0;
    bit exp_conf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, got, exp);
        end
    endtask

    function automatic bit rh(input int c, input int k);
        return (k < 0) ? RV[c] : rawh[c][k];
    endfunction

    // Debounced level flips at an edge once the last D synchronized samples
    // (raw delayed S edges), all taken since the last reset, disagree with it.
    always @(posedge clk) begin
        bit [4:0] raw;
        n = n + 1;
        raw = {bus.input_push_button6_step_7, bus.input_input_switch5_k_6, bus.input_input_switch4_j_5,
               bus.input_input_switch3__clear_4, bus.input_input_switch2__preset_3};
        for (int c = 0; c < 5; c++) rawh[c][n] = raw[c];
        if (rst) begin
            last_rst = n;
            for (int c = 0; c < 5; c++) begin
                for (int k = n - S + 1; k <= n; k++) if (k >= 0) rawh[c][k] = RV[c];
                dh[c][n] = RV[c];
            end
            exp_tick = 0;
            exp_conf = 0;
        end else begin
            bit armed;
            for (int c = 0; c < 5; c++) begin
                bit flip;
                flip = (n - D + 1 > last_rst);
                for (int k = n - D + 1; k <= n && flip; k++) if (rh(c, k - S) == dh[c][n-1]) flip = 0;
                dh[c][n] = flip ? !dh[c][n-1] : dh[c][n-1];
            end
            exp_conf = !dh[0][n-1] && !dh[1][n-1];
            armed = 0;
            for (int j = last_rst + 1; j <= n - 1 - S; j++) if (!rawh[4][j]) armed = 1;
            exp_tick = dh[4][n-1] && !dh[4][n-2] && armed;
        end
    end

    task automatic drive(input bit [4:0] v, input bit r);
        @(negedge clk);
        if (n > 0) begin
            chk("preset_n_db", bus.output_preset_n_db_8, dh[0][n]);
            chk("clear_n_db", bus.output_clear_n_db_9, dh[1][n]);
            chk("j_db", bus.output_j_db_10, dh[2][n]);
            chk("k_db", bus.output_k_db_11, dh[3][n]);
            chk("step_tick", bus.output_step_tick_12, exp_tick);
            chk("conflict", bus.output_conflict_13, exp_conf);
        end
        {bus.input_push_button6_step_7, bus.input_input_switch5_k_6, bus.input_input_switch4_j_5,
         bus.input_input_switch3__clear_4, bus.input_input_switch2__preset_3} = v;
        rst = r;
    endtask

    task automatic hold(input bit [4:0] v, input int cycles, inout int ticks);
        for (int i = 0; i < cycles; i++) begin
            drive(v, 0);
            if (bus.output_step_tick_12) ticks++;
        end
    endtask

    initial begin
        int ticks;
        int jr_edge;
        int j_seen;
        bit [4:0] v;
        {bus.input_push_button6_step_7, bus.input_input_switch5_k_6, bus.input_input_switch4_j_5,
         bus.input_input_switch3__clear_4, bus.input_input_switch2__preset_3} = IDLE;
        for (int c = 0; c < 5; c++) begin
            rawh[c][0] = RV[c];
            dh[c][0] = RV[c];
        end
        drive(IDLE, 1);
        drive(IDLE, 0);
        ticks = 0;
        hold(IDLE, 50, ticks);
        chk("idle_ticks", ticks, 0);
        drive(IDLE | 5'b00100, 0);
        jr_edge = n + 1;
        j_seen = -1;
        for (int i = 0; i < 30; i++) begin
            drive(IDLE | 5'b00100, 0);
            if (bus.output_j_db_10 && j_seen < 0) j_seen = n;
        end
        chk("j_latency", j_seen - jr_edge, D + S - 1);
        chk("k_untouched", bus.output_k_db_11, 0);
        hold(IDLE, 30, ticks);
        foreach (v[i]) v[i] = 0;
        for (int i = 0; i < 6; i++) drive(IDLE | ((i % 2 == 0) ? 5'b01000 : 5'b00000), 0);
        hold(IDLE | 5'b01000, 30, ticks);
        hold(IDLE, 30, ticks);
        hold(IDLE | 5'b01000, 10, ticks);
        hold(IDLE, 30, ticks);
        chk("k_short_pulse", bus.output_k_db_11, 0);
        ticks = 0;
        hold(IDLE | 5'b10000, 100, ticks);
        hold(IDLE, 30, ticks);
        hold(IDLE | 5'b10000, 40, ticks);
        hold(IDLE, 30, ticks);
        chk("step_two_ticks", ticks, 2);
        hold(5'b00000, 30, ticks);
        chk("conflict_on", bus.output_conflict_13, 1);
        hold(5'b00010 & ~5'b00001 | 5'b00010, 30, ticks);
        hold(IDLE, 30, ticks);
        drive(IDLE | 5'b00100, 0);
        for (int i = 0; i < 11; i++) drive(IDLE | 5'b00100, 0);
        drive(IDLE | 5'b00100, 1);
        hold(IDLE | 5'b00100, 40, ticks);
        chk("j_after_reset", bus.output_j_db_10, 1);
        for (int i = 0; i < 60; i++) drive(IDLE | ((i % 2 == 0) ? 5'b00100 : 5'b00000), 0);
        hold(IDLE, 30, ticks);
        drive(IDLE | 5'b10000, 0);
        ticks = 0;
        drive(IDLE | 5'b10000, 1);
        hold(IDLE | 5'b10000, 60, ticks);
        chk("held_through_reset", ticks, 0);
        hold(IDLE, 30, ticks);
        hold(IDLE | 5'b10000, 40, ticks);
        hold(IDLE, 30, ticks);
        chk("repress_tick", ticks, 1);
        for (int seg = 0; seg < 60; seg++) begin
            v = 5'($urandom);
            for (int b = 0; b < int'($urandom_range(0, 4)); b++) drive(5'($urandom), 0);
            if ($urandom_range(0, 14) == 0) drive(v, 1);
            hold(v, $urandom_range(5, 40), ticks);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/jk_switch_conditioner.md
# jk_switch_conditioner

Input-conditioning stage directly upstream of the JK flip-flop block. It takes raw asynchronous switch and push-button levels (preset, clear, J, K, step), synchronizes and debounces each one, and drives clean levels plus a single-cycle step pulse into the flip-flop's control inputs. It also flags an illegal simultaneous preset/clear request.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before a debounced output changes; legal range ≥2
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; legal range ≥2
- input_clock1_c_1  in  1  single clock; all state updates on its rising edge
- input_input_switch1_reset_2  in  1  synchronous, active-high reset
- input_input_switch2__preset_3  in  1  raw preset switch, active-low, asynchronous to the clock
- input_input_switch3__clear_4  in  1  raw clear switch, active-low, asynchronous
- input_input_switch4_j_5  in  1  raw J switch, asynchronous
- input_input_switch5_k_6  in  1  raw K switch, asynchronous
- input_push_button6_step_7  in  1  raw step button, active-high, asynchronous
- output_preset_n_db_8  out  1  debounced preset, active-low
- output_clear_n_db_9  out  1  debounced clear, active-low
- output_j_db_10  out  1  debounced J
- output_k_db_11  out  1  debounced K
- output_step_tick_12  out  1  one-cycle pulse on each debounced step press
- output_conflict_13  out  1  high while debounced preset and clear are both asserted (both low)

## Operation
- Five identical channels: preset, clear, J, K, step. Each channel has a SYNC_STAGES synchronizer, then a debounce counter, then a debounced level register.
- Counter width is clog2(DEBOUNCE_CYCLES)+1. The counter never wraps. Use unsigned compare only.
- Per channel, each cycle, with s = synchronizer output and d = debounced level:
  - s == d: counter goes to 0.
  - s != d and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s != d and counter == DEBOUNCE_CYCLES-1: d takes s, counter goes to 0.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes d. The counter restarts from 0 on every bounce.
- Step channel:
  - The debounced step level is held internally.
  - output_step_tick_12 = debounced level high AND previous-cycle debounced level low, registered.
  - The result is exactly one tick per press, however long the button is held. Release produces no tick.
- output_conflict_13 is a registered NOR of the debounced preset_n and clear_n. This block does not arbitrate the conflict; it forwards both levels unchanged.
- Reset values, applied at the first clock edge with reset high:
  - Preset and clear synchronizers and debounced levels: 1 (deasserted).
  - J, K and step synchronizers and debounced levels: 0.
  - All counters: 0.
  - output_step_tick_12 = 0, output_conflict_13 = 0.
- Reset mid-debounce discards partial counts. After reset releases, an input already held at a non-reset level takes the full latency to appear. No tick is generated for a step button held through reset until it is released and pressed again.

## Timing
- Latency: a raw input that is stable before edge E appears on its debounced output after edge E + SYNC_STAGES - 1 + DEBOUNCE_CYCLES. With the defaults this is 17 edges after E, i.e. 18 edges in total counting E.
- output_step_tick_12 rises one edge after the debounced step level rises, so 1 cycle after that latency. It stays high for exactly 1 cycle.
- output_conflict_13 follows the later of the two debounced assertions by 1 cycle, and deasserts 1 cycle after either debounced level returns to 1.
- Simultaneous changes on different channels are independent. Each channel meets its own latency with no cross-channel skew beyond its own input timing.
- A raw input that toggles every cycle never updates its debounced output.
- Reset has priority over every other update in the same cycle.

## Test plan
- Reset, then all raw inputs idle (preset=1, clear=1, J=K=step=0) for 50 cycles -> preset_n_db=1, clear_n_db=1, j_db=k_db=0, step_tick=0, conflict=0 throughout.
- J raised before edge 10 and held (defaults) -> j_db rises after edge 27, no earlier. k_db is unchanged.
- K bounces 1,0,1,0 over 6 cycles, then held 1 -> k_db rises exactly DEBOUNCE_CYCLES+1 edges after the last bounce. Separately, K pulsed high for 10 cycles only -> k_db stays 0.
- Step held high for 100 cycles, released, pressed again -> exactly 2 step_tick pulses, each 1 cycle wide, each 1 cycle after debounced step rises.
- Preset and clear driven low together -> both debounced outputs go low on the same cycle and conflict rises 1 cycle later. Release clear -> conflict falls 1 cycle after clear_n_db returns to 1.
- J held high; reset pulsed 1 cycle when the J counter is at 10 -> j_db stays 0 and rises a full 17 edges after reset deasserts (defaults).
